if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry first-word-fall-through fetch queue between the IF and ID stages.
- Decouples fetch from decode with a valid/ready handshake on both sides.
- Adds a synchronous flush for branch/jump redirect and inserts a NOP bubble whenever empty or flushing.
- Carries {pc_plus4, inst} per entry.

Parameters:
PC_W, 32, width of pc_plus4 field
INST_W, 32, width of instruction field
DEPTH, 4, queue entries; power of two, legal range 2..8
NOP_INST, 32'h0000_0000, instruction value driven on id_inst when no valid entry is presented (INST_W bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset: asynchronous assert, active-low (0 = reset)
flush  in  1  redirect: discard all queued entries this edge
if_valid  in  1  IF presents an entry
if_ready  out  1  queue can accept an entry this cycle
if_pc_plus4  in  PC_W  fetched PC+4
if_inst  in  INST_W  fetched instruction
id_valid  out  1  ID is presented a real entry
id_ready  in  1  ID consumes the head entry this cycle (0 = decode stall)
id_pc_plus4  out  PC_W  head PC+4, or 0 when not valid
id_inst  out  INST_W  head instruction, or NOP_INST when not valid
occupancy  out  $clog2(DEPTH)+1  number of stored entries

Behaviour:
- Storage: DEPTH-entry circular array with wr_ptr/rd_ptr of $clog2(DEPTH) bits (natural wrap) plus a count register (0..DEPTH). The array is not reset.
- Reset (rst=0, asynchronous): count, wr_ptr, rd_ptr <= 0. During and after reset until the first push:
  - id_valid=0, id_inst=NOP_INST, id_pc_plus4=0, occupancy=0
  - if_ready=1 once rst=1
- Reset mid-operation discards all entries immediately, with no clock required.
- if_ready = (count != DEPTH) && !flush. It is combinational and must not depend on if_valid.
- push = if_valid && if_ready. On the edge, write {if_pc_plus4, if_inst} at wr_ptr and increment wr_ptr.
- id_valid = (count != 0) && !flush.
- id_inst / id_pc_plus4 = array[rd_ptr] when id_valid, else NOP_INST / 0. These are combinational from registered state only, with no path from the if_* inputs.
- pop = id_valid && id_ready. On the edge, increment rd_ptr.
- count update on the edge:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Latency: an entry pushed at edge N is visible on id_* in the cycle after edge N. Minimum IF-to-ID latency is 1 cycle; there is no same-cycle bypass.
- Full (count=DEPTH): if_ready=0, even if pop occurs the same cycle. Push-while-full is therefore impossible, and the bench checks count never exceeds DEPTH.
- Empty (count=0): no pop is possible and outputs show the bubble. A simultaneous push is accepted.
- Stall (id_ready=0): the head and all outputs hold. IF may keep filling until full.
- Flush (synchronous, priority over push/pop): at an edge with flush=1, count, wr_ptr, rd_ptr <= 0. Any push and pop in that cycle are ignored.
  - During the flush cycle, id_valid=0 and id_* show the bubble, so ID sees a NOP exactly as the old stall-clear behaviour did.
  - Flush with id_ready=0 behaves identically.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no special handling. Ordering is strictly FIFO.
- occupancy = count, registered.

Test Plan:
- Reset and empty:
  - Stimulus: hold rst=0 for 3 cycles, release, keep if_valid=0.
  - Required: id_valid=0, id_inst=0x00000000, id_pc_plus4=0, occupancy=0, if_ready=1 every cycle.
- Single pass-through:
  - Stimulus: push {0x00000004, 0x24010005} with id_ready=1.
  - Required: on the next cycle id_valid=1 with those values; after the pop edge id_valid=0 and occupancy=0.
- Fill under stall, DEPTH=4:
  - Stimulus: id_ready=0, push pc 0x4, 0x8, 0xC, 0x10 back-to-back.
  - Required: occupancy reaches 4 and if_ready=0.
  - Stimulus: 5th if_valid held high with a pop in the same cycle.
  - Required: the 5th entry is not accepted that cycle.
  - Stimulus: release id_ready=1.
  - Required: pops come out in order 0x4, 0x8, 0xC, 0x10.
- Wrap-around:
  - Stimulus: 10 continuous push+pop cycles with pc 0x4..0x28.
  - Required: occupancy stays 1 and the output sequence is exact across the pointer wrap.
- Flush:
  - Stimulus: with 3 entries queued, assert flush for 1 cycle while if_valid=1 and id_ready=1.
  - Required: in that cycle id_valid=0, id_inst=NOP_INST, if_ready=0.
  - Required: after the edge occupancy=0, and the flush-cycle IF entry is not stored.
  - Required: the next push appears alone.
- Asynchronous reset mid-stream:
  - Stimulus: with 2 entries queued, drop rst=0 between clock edges.
  - Required: id_valid=0 and occupancy=0 immediately, without a clock edge, and the old entries never reappear after release.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID fetch queue: DEPTH-entry first-word-fall-through FIFO carrying
// {pc_plus4, inst} from fetch to decode. Flush clears the queue and forces a
// NOP bubble. When no real entry is presented, ID sees a bubble.
module if_id_queue #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [PC_W-1:0]            if_pc_plus4,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [PC_W-1:0]            id_pc_plus4,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc_plus4;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  entry_t           head;

  // Handshakes: full blocks pushes even if a pop happens the same cycle, and
  // flush hides the head and refuses new entries.
  always_comb begin
    if_ready = (count_q != CNT_W'(DEPTH)) && !flush;
    id_valid = (count_q != '0) && !flush;
    push     = if_valid && if_ready;
    pop      = id_valid && id_ready;
  end

  // Head presentation from registered state only; bubble when nothing valid.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    id_pc_plus4 = '0;
    id_inst     = NOP_INST;
    if (id_valid) begin
      id_pc_plus4 = head.pc_plus4;
      id_inst     = head.inst;
    end
  end

  // Next-state for pointers and count; flush takes priority over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state; asynchronous reset empties the queue with no clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; not reset since count gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc_plus4: if_pc_plus4, inst: if_inst};
  end

  assign occupancy = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): reset, pass-through, fill under
// stall, pointer wrap, flush and mid-stream asynchronous reset.
module tb_if_id_queue;

  localparam int PC_W = 32, INST_W = 32, DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              if_valid;
  logic              if_ready;
  logic [PC_W-1:0]   if_pc_plus4;
  logic [INST_W-1:0] if_inst;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc_plus4;
  logic [INST_W-1:0] id_inst;
  logic [2:0]        occupancy;

  int n_checks = 0;
  int n_fails  = 0;

  if_id_queue #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bubble state: nothing presented, queue empty.
  task automatic chk_empty(input string tag);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'd0);
    chk({tag, ".id_inst"}, 64'(id_inst), 64'h0);
    chk({tag, ".id_pc"}, 64'(id_pc_plus4), 64'h0);
    chk({tag, ".occ"}, 64'(occupancy), 64'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'd1);
    chk({tag, ".id_pc"}, 64'(id_pc_plus4), 64'(pc));
    chk({tag, ".id_inst"}, 64'(id_inst), 64'(inst));
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc_plus4 = '0; if_inst = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_empty("rst");
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_empty("idle");
      chk("idle.if_ready", 64'(if_ready), 64'd1);
      tick();
    end

    // Single pass-through
    if_valid = 1'b1; if_pc_plus4 = 32'h4; if_inst = 32'h2401_0005; id_ready = 1'b1;
    #1;
    chk("single.no_bypass", 64'(id_valid), 64'd0);
    tick();
    if_valid = 1'b0;
    #1;
    chk_head("single", 32'h4, 32'h2401_0005);
    chk("single.occ", 64'(occupancy), 64'd1);
    tick();
    #1;
    chk_empty("single.after");

    // Fill under stall
    id_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if_valid = 1'b1; if_pc_plus4 = 32'(4 * i); if_inst = 32'h1000 + 32'(i);
      #1;
      chk("fill.if_ready", 64'(if_ready), 64'd1);
      tick();
      #1;
      chk("fill.occ", 64'(occupancy), 64'(i));
    end
    chk("fill.full_ready", 64'(if_ready), 64'd0);
    chk_head("fill.head", 32'h4, 32'h1001);
    // 5th offered while a pop happens: refused
    if_valid = 1'b1; if_pc_plus4 = 32'h14; if_inst = 32'h1005; id_ready = 1'b1;
    #1;
    chk("fill.5th_ready", 64'(if_ready), 64'd0);
    chk_head("fill.pop0", 32'h4, 32'h1001);
    tick();
    if_valid = 1'b0;
    #1;
    chk("fill.occ_after5", 64'(occupancy), 64'd3);
    chk("fill.occ_le_depth", 64'(occupancy <= 3'(DEPTH)), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      chk_head("fill.order", 32'(4 * i), 32'h1000 + 32'(i));
      tick();
      #1;
    end
    chk_empty("fill.drained");

    // Wrap-around: prime one entry, then push+pop every cycle
    if_valid = 1'b1; if_pc_plus4 = 32'h4; if_inst = 32'hA000_0004; id_ready = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      if_pc_plus4 = 32'(4 * (k + 1)); if_inst = 32'hA000_0000 | 32'(4 * (k + 1));
      #1;
      chk_head("wrap", 32'(4 * k), 32'hA000_0000 | 32'(4 * k));
      chk("wrap.occ", 64'(occupancy), 64'd1);
      tick();
    end
    if_valid = 1'b0;
    #1;
    chk_head("wrap.last", 32'h28, 32'hA000_0028);
    tick();
    #1;
    chk_empty("wrap.drained");

    // Flush with 3 queued
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_pc_plus4 = 32'h100 + 32'(4 * i); if_inst = 32'hB000_0000 + 32'(i);
      tick();
    end
    flush = 1'b1; if_valid = 1'b1; if_pc_plus4 = 32'h200; if_inst = 32'hDEAD_BEEF; id_ready = 1'b1;
    #1;
    chk("flush.id_valid", 64'(id_valid), 64'd0);
    chk("flush.id_inst", 64'(id_inst), 64'h0);
    chk("flush.id_pc", 64'(id_pc_plus4), 64'h0);
    chk("flush.if_ready", 64'(if_ready), 64'd0);
    chk("flush.occ_before", 64'(occupancy), 64'd3);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    chk_empty("flush.after");
    if_valid = 1'b1; if_pc_plus4 = 32'h300; if_inst = 32'hC000_0300;
    tick();
    if_valid = 1'b0;
    #1;
    chk_head("flush.next", 32'h300, 32'hC000_0300);
    chk("flush.next_occ", 64'(occupancy), 64'd1);
    tick();
    #1;
    chk_empty("flush.next_drained");

    // Asynchronous reset mid-stream
    id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if_valid = 1'b1; if_pc_plus4 = 32'h400 + 32'(4 * i); if_inst = 32'hE000_0000 + 32'(i);
      tick();
    end
    if_valid = 1'b0;
    #1;
    chk("arst.occ_before", 64'(occupancy), 64'd2);
    #1;
    rst = 1'b0;
    #1;
    chk_empty("arst.now");
    tick();
    rst = 1'b1; id_ready = 1'b1;
    #1;
    chk_empty("arst.release");
    tick();
    #1;
    chk_empty("arst.later");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
